// File: rtl/rx_fifo_pkg.sv
// rx_fifo_pkg: shared sizing helpers and the byte type for the UART receive FIFO.
//   ptr_width(depth)   - bits needed to address a DEPTH-entry circular buffer
//   count_width(depth) - bits needed to hold an occupancy of 0..DEPTH inclusive
//   rx_byte_t          - one received UART byte
package rx_fifo_pkg;

    typedef logic [7:0] rx_byte_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so that a completely full buffer (count == depth) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rx_byte_fifo_if.sv
// rx_byte_fifo_if: producer/consumer bundle around the receive byte FIFO.
//   i_data, i_valid          - write side, driven by the UART receiver strobe
//   o_data, o_valid, i_ready - first-word-fall-through read handshake
//   o_data_ready_n           - active-low copy of o_valid for the legacy controller input
//   o_count                  - bytes held, head included
//   o_overflow               - sticky dropped-byte flag, cleared by i_clear_overflow
//   slave modport: the FIFO itself; master modport: the surrounding logic / bench
interface rx_byte_fifo_if
    import rx_fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]         i_data;
    logic                          i_valid;
    logic [DATA_WIDTH-1:0]         o_data;
    logic                          o_valid;
    logic                          i_ready;
    logic                          o_data_ready_n;
    logic [count_width(DEPTH)-1:0] o_count;
    logic                          o_overflow;
    logic                          i_clear_overflow;

    modport slave (
        input  i_data, i_valid, i_ready, i_clear_overflow,
        output o_data, o_valid, o_data_ready_n, o_count, o_overflow
    );

    modport master (
        output i_data, i_valid, i_ready, i_clear_overflow,
        input  o_data, o_valid, o_data_ready_n, o_count, o_overflow
    );
endinterface

// File: rtl/rx_fifo_mem.sv
// rx_fifo_mem: DEPTH x DATA_WIDTH register array, one synchronous write port and
// one asynchronous read port; deliberately unreset so it maps onto plain storage.
//   clk_in       - system clock
//   we/waddr/wdata - write port, captured on the rising edge
//   raddr/rdata  - combinational read port
module rx_fifo_mem
    import rx_fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
)(
    input  logic                            clk_in,
    input  logic                            we,
    input  logic [ptr_width(DEPTH)-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic [ptr_width(DEPTH)-1:0]     raddr,
    output logic [DATA_WIDTH-1:0]           rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: elastic first-word-fall-through byte buffer between uart_rx and
// control_module. Captures a byte on each i_valid pulse, holds up to DEPTH bytes,
// keeps the oldest data on overflow and flags every dropped byte.
//   clk_in - system clock
//   reset  - asynchronous active-low reset
//   bus    - rx_byte_fifo_if slave modport (write strobe, read handshake, status)
module rx_byte_fifo
    import rx_fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
)(
    input  logic          clk_in,
    input  logic          reset,
    rx_byte_fifo_if.slave bus
);
    localparam int            PW   = ptr_width(DEPTH);
    localparam int            CW   = count_width(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4) begin : g_bad_depth
        $error("rx_byte_fifo: DEPTH must be a power of two and at least 4");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q, head_d, mem_rdata;
    logic                  valid_q, valid_d, ovf_q, ovf_d;
    logic                  push, pop, drop;

    rx_fifo_mem #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
        .clk_in (clk_in),
        .we     (push),
        .waddr  (wr_ptr_q),
        .wdata  (bus.i_data),
        .raddr  (rd_next),
        .rdata  (mem_rdata)
    );

    always_comb begin
        pop      = valid_q && bus.i_ready;
        push     = bus.i_valid && (count_q < FULL || pop);
        drop     = bus.i_valid && !push;
        rd_next  = rd_ptr_q + PW'(1);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_next : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        valid_d  = count_d != '0;
        // A dropped byte in the same cycle as a clear keeps the flag set.
        ovf_d    = drop || (ovf_q && !bus.i_clear_overflow);
        // The next head comes from memory when at least two bytes are held; otherwise
        // the byte being pushed now (not yet in memory) must be bypassed into the head.
        head_d   = (pop && count_q > CW'(1)) ? mem_rdata :
                   (push && count_q == CW'(pop)) ? bus.i_data : head_q;
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.o_data         = head_q;
    assign bus.o_valid        = valid_q;
    assign bus.o_data_ready_n = !valid_q;
    assign bus.o_count        = count_q;
    assign bus.o_overflow     = ovf_q;
endmodule

// File: tb/tb_rx_byte_fifo.sv
// tb_rx_byte_fifo: directed plan plus random traffic against a queue-based model.
module tb_rx_byte_fifo;
    import rx_fifo_pkg::*;
    localparam int DEPTH = 16;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    rx_byte_fifo_if #(.DEPTH(DEPTH), .DATA_WIDTH(8)) bus ();

    rx_byte_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(8)) dut (
        .clk_in (clk_in),
        .reset  (rst_n),
        .bus    (bus)
    );

    int       n_cmp = 0;
    int       n_bad = 0;
    rx_byte_t mq[$];
    logic     m_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic v, input rx_byte_t d, input logic r, input logic clr);
        logic pop, push;
        pop  = mq.size() != 0 && r;
        push = v && (mq.size() < DEPTH || pop);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(d);
        m_ovf = (v && !push) ? 1'b1 : clr ? 1'b0 : m_ovf;
    endtask

    task automatic compare_model();
        chk("m_valid", 32'(bus.o_valid), 32'(mq.size() != 0));
        chk("m_ready_n", 32'(bus.o_data_ready_n), 32'(mq.size() == 0));
        chk("m_count", 32'(bus.o_count), 32'(mq.size()));
        chk("m_ovf", 32'(bus.o_overflow), 32'(m_ovf));
        if (mq.size() != 0) chk("m_data", 32'(bus.o_data), 32'(mq[0]));
    endtask

    task automatic cyc(input logic v, input rx_byte_t d, input logic r, input logic clr);
        bus.i_valid          = v;
        bus.i_data           = d;
        bus.i_ready          = r;
        bus.i_clear_overflow = clr;
        @(posedge clk_in);
        model_step(v, d, r, clr);
        @(negedge clk_in);
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        #2 rst_n = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.o_valid), 0);
        chk("rst_count", 32'(bus.o_count), 0);
        @(negedge clk_in);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.i_valid = 0; bus.i_data = 0; bus.i_ready = 0; bus.i_clear_overflow = 0;
        #12;
        chk("reset_valid", 32'(bus.o_valid), 0);
        chk("reset_ready_n", 32'(bus.o_data_ready_n), 1);
        chk("reset_data", 32'(bus.o_data), 0);
        chk("reset_count", 32'(bus.o_count), 0);
        chk("reset_ovf", 32'(bus.o_overflow), 0);
        @(negedge clk_in);
        rst_n = 1'b1;

        // 1: single byte in and out
        cyc(1, 8'h41, 0, 0);
        chk("t1_valid", 32'(bus.o_valid), 1);
        chk("t1_data", 32'(bus.o_data), 32'h41);
        chk("t1_count", 32'(bus.o_count), 1);
        cyc(0, 8'h00, 1, 0);
        chk("t1_pop_valid", 32'(bus.o_valid), 0);
        chk("t1_pop_count", 32'(bus.o_count), 0);
        chk("t1_pop_ready_n", 32'(bus.o_data_ready_n), 1);

        // 2: fill, overflow, drain
        for (int i = 0; i < 16; i++) cyc(1, rx_byte_t'(i), 0, 0);
        chk("t2_full_count", 32'(bus.o_count), 16);
        chk("t2_full_ovf", 32'(bus.o_overflow), 0);
        cyc(1, 8'hAA, 0, 0);
        chk("t2_ovf", 32'(bus.o_overflow), 1);
        chk("t2_ovf_count", 32'(bus.o_count), 16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain", 32'(bus.o_data), i);
            cyc(0, 8'h00, 1, 0);
        end
        chk("t2_empty", 32'(bus.o_valid), 0);

        // 3: full with simultaneous push and pop
        for (int i = 0; i < 16; i++) cyc(1, rx_byte_t'(i), 0, 0);
        chk("t3_head", 32'(bus.o_data), 0);
        cyc(1, 8'h55, 1, 0);
        chk("t3_count", 32'(bus.o_count), 16);
        chk("t3_ovf", 32'(bus.o_overflow), 1);
        for (int i = 1; i < 17; i++) begin
            chk("t3_drain", 32'(bus.o_data), i == 16 ? 32'h55 : i);
            cyc(0, 8'h00, 1, 0);
        end
        chk("t3_empty", 32'(bus.o_count), 0);

        // 4: streaming wrap-around
        begin
            int got = 0;
            for (int i = 0; i < 41; i++) begin
                if (bus.o_valid) begin
                    chk("t4_order", 32'(bus.o_data), 32'h10 + got);
                    got++;
                end
                cyc(i < 40, rx_byte_t'(8'h10 + i), 1, 0);
                chk("t4_count_le1", 32'(bus.o_count <= 1), 1);
            end
            chk("t4_total", got, 40);
        end

        // 5: asynchronous reset with bytes held
        for (int i = 0; i < 5; i++) cyc(1, rx_byte_t'(8'h60 + i), 0, 0);
        chk("t5_held", 32'(bus.o_count), 5);
        do_reset();
        cyc(1, 8'h7E, 0, 0);
        chk("t5_first", 32'(bus.o_data), 32'h7E);
        cyc(0, 8'h00, 1, 0);

        // 6: overflow set beats clear
        for (int i = 0; i < 17; i++) cyc(1, rx_byte_t'(8'h80 + i), 0, 0);
        chk("t6_set", 32'(bus.o_overflow), 1);
        cyc(1, 8'h99, 0, 1);
        chk("t6_set_wins", 32'(bus.o_overflow), 1);
        cyc(0, 8'h00, 0, 1);
        chk("t6_cleared", 32'(bus.o_overflow), 0);

        // random traffic with bursts biased toward filling and draining
        for (int i = 0; i < 3000; i++) begin
            int phase = (i / 200) % 3;
            cyc($urandom_range(0, 3) < (phase == 0 ? 3 : 1),
                rx_byte_t'($urandom),
                $urandom_range(0, 3) < (phase == 1 ? 3 : 1),
                $urandom_range(0, 15) == 0);
            if (i == 1500) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
